// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers horizontal/vertical position from HS/VS sync inputs,
// measures line period and HS pulse width, and locks once the expected line
// timing has been seen on several consecutive lines.
module vga_sync_decoder #(
    parameter int H_TOTAL    = 800,
    parameter int HS_WIDTH   = 97,
    parameter int LOCK_LINES = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        pix_en,
    input  logic        HS,
    input  logic        VS,
    output logic [31:0] hCount,
    output logic [15:0] vCount,
    output logic [15:0] hPeriod,
    output logic [15:0] hsWidth,
    output logic        lineStart,
    output logic        frameStart,
    output logic        locked
);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [31:0] TIMEOUT_CNT = 32'(2 * H_TOTAL - 1);
    localparam logic [15:0] H_TOTAL_16  = 16'(H_TOTAL);
    localparam logic [15:0] HS_WIDTH_16 = 16'(HS_WIDTH);
    localparam logic [15:0] LOCK_16     = 16'(LOCK_LINES);

    state_t      state_q, state_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic [31:0] hcount_q, hcount_d;
    logic [15:0] hperiod_q, hperiod_d;
    logic [15:0] pulse_cnt_q, pulse_cnt_d;
    logic [15:0] hswidth_q, hswidth_d;
    logic [15:0] vcount_q, vcount_d;
    logic [15:0] good_lines_q, good_lines_d;
    logic        line_start_q, line_start_d;
    logic        frame_start_q, frame_start_d;
    logic        locked_q, locked_d;

    logic        hs_rise;
    logic        hs_fall;
    logic        vs_rise;
    logic        good_line;
    logic        timeout;

    // Edge detection is qualified by pix_en so edges exist only on pixel ticks.
    always_comb begin
        hs_rise = pix_en & HS & ~hs_q;
        hs_fall = pix_en & ~HS & hs_q;
        vs_rise = pix_en & VS & ~vs_q;
    end

    // Counters and measurements; everything holds on clocks without a pixel tick.
    always_comb begin
        hs_d        = hs_q;
        vs_d        = vs_q;
        hcount_d    = hcount_q;
        hperiod_d   = hperiod_q;
        pulse_cnt_d = pulse_cnt_q;
        hswidth_d   = hswidth_q;
        vcount_d    = vcount_q;
        if (pix_en) begin
            hs_d = HS;
            vs_d = VS;
            if (hs_rise) begin
                hcount_d = 32'd0;
            end else if (hcount_q != 32'hFFFF_FFFF) begin
                hcount_d = hcount_q + 32'd1;
            end
            if (hs_rise) begin
                // Period is the tick count since the previous rising edge.
                if (hcount_q >= 32'h0000_FFFF) begin
                    hperiod_d = 16'hFFFF;
                end else begin
                    hperiod_d = hcount_q[15:0] + 16'd1;
                end
            end
            if (hs_rise) begin
                pulse_cnt_d = 16'd1;
            end else if (HS && pulse_cnt_q != 16'hFFFF) begin
                pulse_cnt_d = pulse_cnt_q + 16'd1;
            end
            if (hs_fall) begin
                hswidth_d = pulse_cnt_q;
            end
            // A frame start wins over the line increment on the same tick.
            if (vs_rise) begin
                vcount_d = 16'd0;
            end else if (hs_rise) begin
                vcount_d = vcount_q + 16'd1;
            end
        end
    end

    // Lock FSM next-state: a line is judged by the freshly measured period and last pulse width.
    always_comb begin
        state_d       = state_q;
        good_lines_d  = good_lines_q;
        good_line     = (hperiod_d == H_TOTAL_16) && (hswidth_q == HS_WIDTH_16);
        timeout       = pix_en & ~hs_rise & (hcount_d >= TIMEOUT_CNT);
        line_start_d  = hs_rise;
        frame_start_d = vs_rise;
        case (state_q)
            SEARCH: begin
                if (hs_rise) begin
                    state_d      = CHECK;
                    good_lines_d = 16'd0;
                end
            end
            CHECK: begin
                if (hs_rise) begin
                    if (good_line) begin
                        good_lines_d = good_lines_q + 16'd1;
                        if (good_lines_q + 16'd1 >= LOCK_16) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        good_lines_d = 16'd0;
                    end
                end else if (timeout) begin
                    state_d      = SEARCH;
                    good_lines_d = 16'd0;
                end
            end
            LOCKED: begin
                if (hs_rise) begin
                    if (!good_line) begin
                        state_d      = SEARCH;
                        good_lines_d = 16'd0;
                    end
                end else if (timeout) begin
                    state_d      = SEARCH;
                    good_lines_d = 16'd0;
                end
            end
            default: begin
                state_d      = SEARCH;
                good_lines_d = 16'd0;
            end
        endcase
        locked_d = (state_d == LOCKED);
    end

    // State register; reset clears every measurement so nothing stale survives.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= SEARCH;
            hs_q          <= 1'b0;
            vs_q          <= 1'b0;
            hcount_q      <= 32'd0;
            hperiod_q     <= 16'd0;
            pulse_cnt_q   <= 16'd0;
            hswidth_q     <= 16'd0;
            vcount_q      <= 16'd0;
            good_lines_q  <= 16'd0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            locked_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            hcount_q      <= hcount_d;
            hperiod_q     <= hperiod_d;
            pulse_cnt_q   <= pulse_cnt_d;
            hswidth_q     <= hswidth_d;
            vcount_q      <= vcount_d;
            good_lines_q  <= good_lines_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            locked_q      <= locked_d;
        end
    end

    assign hCount     = hcount_q;
    assign vCount     = vcount_q;
    assign hPeriod    = hperiod_q;
    assign hsWidth    = hswidth_q;
    assign lineStart  = line_start_q;
    assign frameStart = frame_start_q;
    assign locked     = locked_q;

endmodule
